// File: rtl/fm_audio_out.sv
// fm_audio_out
//   Output stage for the FM synthesizer. Every DIV clocks it captures the three
//   offset-binary voice samples and their controls. On the next cycle it mixes
//   them into one saturated 12-bit offset-binary sample. A first-order
//   sigma-delta modulator turns that sample into a 1-bit stream for the RC
//   audio filter pin.
//
//   Optional feature: define FMOUT_DITHER_EN to add 2-bit LFSR dither ahead of
//   the sigma-delta stage. With the macro undefined, the stage sees mix_out
//   directly.
//
//   Ports
//     clk_i                  system clock
//     rst_n                  asynchronous active-low reset
//     sample_raw_1..3 [11:0] voice samples, offset binary (12'h800 = silence)
//     ch_en [2:0]            per-voice enable, bit k -> voice k+1
//     mute                   forces silence on the captured tick
//     atten [2:0]            master attenuation, arithmetic right shift 0..7
//     mix_out [11:0]         mixed sample, offset binary
//     mix_valid              one-cycle pulse when mix_out updates
//     pdm_o                  sigma-delta bitstream

module fm_audio_out #(
    parameter int DIV = 256
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [11:0] sample_raw_1,
    input  logic [11:0] sample_raw_2,
    input  logic [11:0] sample_raw_3,
    input  logic [2:0]  ch_en,
    input  logic        mute,
    input  logic [2:0]  atten,
    output logic [11:0] mix_out,
    output logic        mix_valid,
    output logic        pdm_o
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0] div_cnt_q, div_cnt_d;
    logic        tick;

    logic [11:0] s1_q, s2_q, s3_q;
    logic [2:0]  en_q, atten_q;
    logic        mute_q;
    logic        cap_q;

    logic signed [13:0] sum, att;
    logic [11:0]        sat;
    logic [11:0]        mix_d;
    logic [11:0]        mix_q;
    logic               valid_q;

    logic [11:0] sd_in;
    logic [11:0] acc_q;
    logic [12:0] acc_sum;
    logic        pdm_q;

    // Sample-tick counter
    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + 16'd1;
        if (tick) div_cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) div_cnt_q <= '0;
        else        div_cnt_q <= div_cnt_d;
    end

    // Capture stage: only the values present on the tick cycle are used
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            en_q    <= '0;
            mute_q  <= 1'b0;
            atten_q <= '0;
            cap_q   <= 1'b0;
        end else begin
            cap_q <= tick;
            if (tick) begin
                s1_q    <= sample_raw_1;
                s2_q    <= sample_raw_2;
                s3_q    <= sample_raw_3;
                en_q    <= ch_en;
                mute_q  <= mute;
                atten_q <= atten;
            end
        end
    end

    // Offset binary -> sign-extended two's complement, zero when disabled
    function automatic logic signed [13:0] voice(input logic [11:0] raw, input logic en);
        logic [11:0] tc;
        tc = {~raw[11], raw[10:0]};
        return en ? $signed({{2{tc[11]}}, tc}) : 14'sd0;
    endfunction

    // Mix stage: the worst case of three full-scale voices (-6144..+6141)
    // still fits in 14 bits, so the sum cannot overflow before the clamp
    always_comb begin
        sum = voice(s1_q, en_q[0]) + voice(s2_q, en_q[1]) + voice(s3_q, en_q[2]);
        att = sum >>> atten_q;
        if (att > 14'sd2047)       sat = 12'h7FF;
        else if (att < -14'sd2048) sat = 12'h800;
        else                       sat = att[11:0];
        mix_d = {~sat[11], sat[10:0]};
        if (mute_q) mix_d = 12'h800;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mix_q   <= 12'h800;
            valid_q <= 1'b0;
        end else begin
            valid_q <= cap_q;
            if (cap_q) mix_q <= mix_d;
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = valid_q;

`ifdef FMOUT_DITHER_EN
    // 8-bit Fibonacci LFSR, taps 8,6,5,4; its two low bits are added to the
    // sample, saturating at full scale
    logic [7:0]  lfsr_q;
    logic [12:0] sd_wide;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'hA5;
        else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_comb begin
        sd_wide = {1'b0, mix_q} + {11'b0, lfsr_q[1:0]};
        sd_in   = sd_wide[12] ? 12'hFFF : sd_wide[11:0];
    end
`else
    assign sd_in = mix_q;
`endif

    // First-order sigma-delta: the carry out of the modulo-4096 accumulator
    // is the output bit, so the ones density equals sd_in/4096
    assign acc_sum = {1'b0, acc_q} + {1'b0, sd_in};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_sum[11:0];
            pdm_q <= acc_sum[12];
        end
    end

    assign pdm_o = pdm_q;

endmodule

// File: tb/tb_fm_audio_out.sv
module tb_fm_audio_out;

    localparam int DIV = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sample_raw_1 = 12'h800;
    logic [11:0] sample_raw_2 = 12'h800;
    logic [11:0] sample_raw_3 = 12'h800;
    logic [2:0]  ch_en = 3'b000;
    logic        mute = 1'b0;
    logic [2:0]  atten = 3'd0;
    logic [11:0] mix_out;
    logic        mix_valid;
    logic        pdm_o;

    int n_cmp = 0;
    int n_bad = 0;

    fm_audio_out #(.DIV(DIV)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .sample_raw_1 (sample_raw_1),
        .sample_raw_2 (sample_raw_2),
        .sample_raw_3 (sample_raw_3),
        .ch_en        (ch_en),
        .mute         (mute),
        .atten        (atten),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .pdm_o        (pdm_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0] s1, s2, s3;
        logic [2:0]  en;
        logic        mu;
        logic [2:0]  at;
        logic [11:0] exp;
    } vec_t;

    vec_t tv[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic drive(input vec_t v);
        sample_raw_1 = v.s1;
        sample_raw_2 = v.s2;
        sample_raw_3 = v.s3;
        ch_en        = v.en;
        mute         = v.mu;
        atten        = v.at;
    endtask

    // Counts falling edges until mix_valid is seen high; bounded
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int k = 0; k < 4 * DIV + 8; k++) begin
            @(negedge clk_i);
            cyc++;
            if (mix_valid) return;
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Reference mixer from the arithmetic rules, in plain integers
    function automatic int ref_mix(input vec_t v);
        int s, a;
        s = 0;
        if (v.en[0]) s += int'(v.s1) - 2048;
        if (v.en[1]) s += int'(v.s2) - 2048;
        if (v.en[2]) s += int'(v.s3) - 2048;
        a = s >>> v.at;
        if (a > 2047)  a = 2047;
        if (a < -2048) a = -2048;
        if (v.mu) return 2048;
        return a + 2048;
    endfunction

    function automatic logic [11:0] rnd_sample();
        case ($urandom_range(0, 5))
            0:       return 12'h000;
            1:       return 12'hFFF;
            2:       return 12'h800;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.s1  = rnd_sample();
        v.s2  = rnd_sample();
        v.s3  = rnd_sample();
        v.en  = 3'($urandom_range(0, 7));
        v.mu  = ($urandom_range(0, 7) == 0);
        v.at  = 3'($urandom_range(0, 7));
        v.exp = 12'h000;
        return v;
    endfunction

    task automatic pdm_window(input string nm, input int lo, input int hi);
        int ones;
        ones = 0;
        repeat (4096) begin
            @(negedge clk_i);
            if (pdm_o) ones++;
        end
        check_range(nm, ones, lo, hi);
    endtask

    initial begin
        int   cyc;
        vec_t v, hold;

        //            s1       s2       s3       en      mu    at    exp
        tv[0]  = '{12'h800, 12'h800, 12'h800, 3'b111, 1'b0, 3'd0, 12'h800};
        tv[1]  = '{12'hFFF, 12'hFFF, 12'hFFF, 3'b111, 1'b0, 3'd0, 12'hFFF};
        tv[2]  = '{12'hFFF, 12'hFFF, 12'hFFF, 3'b111, 1'b0, 3'd2, 12'hDFF};
        tv[3]  = '{12'hC00, 12'h000, 12'h000, 3'b001, 1'b0, 3'd0, 12'hC00};
        tv[4]  = '{12'hC00, 12'h000, 12'h000, 3'b000, 1'b0, 3'd0, 12'h800};
        tv[5]  = '{12'h000, 12'h000, 12'h000, 3'b111, 1'b0, 3'd0, 12'h000};
        tv[6]  = '{12'hFFF, 12'hFFF, 12'h000, 3'b111, 1'b0, 3'd0, 12'hFFE};
        tv[7]  = '{12'hFFF, 12'hFFF, 12'hFFF, 3'b111, 1'b1, 3'd0, 12'h800};
        tv[8]  = '{12'h000, 12'h000, 12'hFFF, 3'b100, 1'b0, 3'd7, 12'h80F};
        tv[9]  = '{12'h000, 12'h000, 12'h000, 3'b111, 1'b0, 3'd2, 12'h200};
        tv[10] = '{12'h001, 12'h800, 12'h800, 3'b001, 1'b0, 3'd3, 12'h700};
        tv[11] = '{12'h400, 12'h123, 12'hABC, 3'b001, 1'b0, 3'd0, 12'h400};

        // Reset state
        drive(tv[0]);
        repeat (2) @(negedge clk_i);
        check("reset_mix_out", 32'(mix_out), 32'h800);
        check("reset_mix_valid", 32'(mix_valid), 32'd0);
        check("reset_pdm", 32'(pdm_o), 32'd0);

        // First valid lands at cycle DIV after release (cycle 0 = first edge)
        rst_n = 1'b1;
        wait_valid(cyc);
        check("first_valid_cycle", 32'(cyc), 32'(DIV + 1));
        check("vec0_mix", 32'(mix_out), 32'(tv[0].exp));

        for (int i = 1; i < 12; i++) begin
            drive(tv[i]);
            wait_valid(cyc);
            check($sformatf("vec%0d_period", i), 32'(cyc), 32'(DIV));
            check($sformatf("vec%0d_mix", i), 32'(mix_out), 32'(tv[i].exp));
        end

        // Sigma-delta density: mix_out is held at 12'h400 by tv[11]
        @(negedge clk_i);
        pdm_window("pdm_400", 1023, 1025);

        drive(tv[1]);
        wait_valid(cyc);
        @(negedge clk_i);
        pdm_window("pdm_fff", 4094, 4096);

        drive(tv[5]);
        wait_valid(cyc);
        check("zero_mix", 32'(mix_out), 32'h000);
        @(negedge clk_i);
        pdm_window("pdm_zero", 0, 0);

        // Mute pulsed between ticks must be ignored
        drive(tv[3]);
        wait_valid(cyc);
        mute = 1'b1;
        @(negedge clk_i);
        mute = 1'b0;
        wait_valid(cyc);
        check("mute_glitch_ignored", 32'(mix_out), 32'hC00);
        mute = 1'b1;
        wait_valid(cyc);
        check("mute_held", 32'(mix_out), 32'h800);
        mute = 1'b0;
        wait_valid(cyc);
        check("mute_released", 32'(mix_out), 32'hC00);

        // Asynchronous reset mid-period
        @(negedge clk_i);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mix_out", 32'(mix_out), 32'h800);
        check("async_rst_valid", 32'(mix_valid), 32'd0);
        check("async_rst_pdm", 32'(pdm_o), 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        wait_valid(cyc);
        check("rst_first_valid_cycle", 32'(cyc), 32'(DIV + 1));
        check("rst_first_mix", 32'(mix_out), 32'hC00);

        // Random: junk between ticks, real values only on the tick cycle
        for (int i = 0; i < 200; i++) begin
            drive(rnd_vec());
            @(negedge clk_i);
            check("valid_one_cycle", 32'(mix_valid), 32'd0);
            drive(rnd_vec());
            repeat (DIV - 3) @(negedge clk_i);
            v = rnd_vec();
            drive(v);
            wait_valid(cyc);
            check("rand_period", 32'(1 + (DIV - 3) + cyc), 32'(DIV));
            check($sformatf("rand%0d_mix", i), 32'(mix_out), 32'(ref_mix(v)));
        end

        // Inputs changed after the tick must not disturb the held sample
        hold = v;
        drive(rnd_vec());
        @(negedge clk_i);
        check("hold_between_ticks", 32'(mix_out), 32'(ref_mix(hold)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
